matrix_multiply_seq: RTL and testbench

Sequential 5×5 integer matrix multiplier, C = A·B, that streams two matrices in one word at a time and streams the product out over a valid/ready interface. It checks the combinational Gauss-Jordan inverse: feed the original matrix and the computed inverse, and compare the product against identity. It also applies an inverse to a right-hand-side matrix. A single multiply-accumulate datapath is time-shared across all N³ products.

---
 rtl/matrix_multiply_seq_if.sv | 30 +++
 rtl/matrix_multiply_seq.sv | 164 ++++++++++++++++
 tb/tb_matrix_multiply_seq.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/matrix_multiply_seq_if.sv
// ---------------------------------------------------------------------------
// matrix_multiply_seq_if
//   Streaming bus for the sequential matrix multiplier.
//   Input side : in_valid / in_ready / in_data   (A row-major, then B row-major)
//   Output side: out_valid / out_ready / out_data / out_last (C row-major)
//   master : the block feeding operands and consuming results (testbench, host)
//   slave  : the multiplier itself
//   W must match the W of the matrix_multiply_seq instance using this bus.
// ---------------------------------------------------------------------------
interface matrix_multiply_seq_if #(
   parameter int W = 32
);
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in_data;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_data;
   logic         out_last;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_last
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_last
   );
endinterface

// File: rtl/matrix_multiply_seq.sv
// ---------------------------------------------------------------------------
// matrix_multiply_seq
//   Sequential N x N integer matrix multiplier, C = A * B, built around one
//   shared multiply-accumulate datapath. Operands stream in one element per
//   handshake (A then B, both row-major); each C element is produced after N
//   MAC cycles and held on the output until accepted.
//   Arithmetic is two's complement, modulo 2^W (products and sums truncated).
//
// Ports
//   clk   : rising-edge clock
//   rst   : synchronous reset, active high; aborts any load/compute/output
//   bus   : matrix_multiply_seq_if.slave (in_* operand stream, out_* result)
//   busy  : high from the first accepted operand until the last C handshake
// ---------------------------------------------------------------------------
module matrix_multiply_seq #(
   parameter int N = 5,
   parameter int W = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   matrix_multiply_seq_if.slave  bus,
   output logic                  busy
);

   localparam int             IW   = (N > 1) ? $clog2(N) : 1;
   localparam logic [IW-1:0]  LAST = IW'(N - 1);

   typedef enum logic [1:0] {
      S_LOAD,
      S_MAC,
      S_OUT
   } state_t;

   state_t        state, state_next;

   logic [W-1:0]  a_mem [N][N];
   logic [W-1:0]  b_mem [N][N];

   // Load position: ld_b selects the B array, row/col walk row-major.
   logic [IW-1:0] ld_row, ld_col;
   logic          ld_b;

   // Product position: C[i][j], inner index k.
   logic [IW-1:0] i, j, k;
   logic [W-1:0]  acc;
   logic [W-1:0]  prod;
   logic [W-1:0]  acc_sum;

   logic          load_fire;
   logic          load_done;
   logic          out_fire;

   assign load_fire = bus.in_valid && bus.in_ready;
   assign load_done = load_fire && ld_b && (ld_row == LAST) && (ld_col == LAST);
   assign out_fire  = bus.out_valid && bus.out_ready;

   // Low W bits of the signed product equal the low W bits of the unsigned
   // product, so a plain W-bit multiply gives the required truncation.
   assign prod    = a_mem[i][k] * b_mem[k][j];
   assign acc_sum = acc + prod;

   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values regardless of process ordering.
   always_ff @(posedge clk) begin
      if (rst) state <= S_LOAD;
      else     state <= state_next;
   end

   // NOTE: state_next gets a default before the case so no path leaves it
   // unassigned (which would infer a latch).
   always_comb begin
      state_next = state;
      case (state)
         S_LOAD:  if (load_done)  state_next = S_MAC;
         S_MAC:   if (k == LAST)  state_next = S_OUT;
         S_OUT:   if (out_fire)   state_next = bus.out_last ? S_LOAD : S_MAC;
         default:                 state_next = S_LOAD;
      endcase
   end

   // Control, counters and registered outputs. in_ready/out_valid are derived
   // from state_next so they line up with the state they describe.
   always_ff @(posedge clk) begin
      if (rst) begin
         bus.in_ready  <= 1'b0;
         bus.out_valid <= 1'b0;
         bus.out_data  <= '0;
         bus.out_last  <= 1'b0;
         busy          <= 1'b0;
         ld_row        <= '0;
         ld_col        <= '0;
         ld_b          <= 1'b0;
         i             <= '0;
         j             <= '0;
         k             <= '0;
         acc           <= '0;
      end else begin
         bus.in_ready  <= (state_next == S_LOAD);
         bus.out_valid <= (state_next == S_OUT);
         case (state)
            S_LOAD: begin
               if (load_fire) begin
                  if (!ld_b && ld_row == '0 && ld_col == '0) busy <= 1'b1;
                  // Counters wrap back to A[0][0] when the final B word lands.
                  if (ld_col == LAST) begin
                     ld_col <= '0;
                     if (ld_row == LAST) begin
                        ld_row <= '0;
                        ld_b   <= ~ld_b;
                     end else begin
                        ld_row <= ld_row + 1'b1;
                     end
                  end else begin
                     ld_col <= ld_col + 1'b1;
                  end
                  if (load_done) begin
                     i   <= '0;
                     j   <= '0;
                     k   <= '0;
                     acc <= '0;
                  end
               end
            end
            S_MAC: begin
               acc <= acc_sum;
               if (k == LAST) begin
                  bus.out_data <= acc_sum;
                  bus.out_last <= (i == LAST) && (j == LAST);
               end else begin
                  k <= k + 1'b1;
               end
            end
            S_OUT: begin
               if (out_fire) begin
                  acc          <= '0;
                  k            <= '0;
                  bus.out_last <= 1'b0;
                  if (bus.out_last) begin
                     busy <= 1'b0;
                     i    <= '0;
                     j    <= '0;
                  end else if (j == LAST) begin
                     j <= '0;
                     i <= i + 1'b1;
                  end else begin
                     j <= j + 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // NOTE: operand arrays carry no reset; every element is rewritten by the
   // next full load before it is read, so a reset would only add muxing.
   always_ff @(posedge clk) begin
      if (load_fire) begin
         if (ld_b) b_mem[ld_row][ld_col] <= bus.in_data;
         else      a_mem[ld_row][ld_col] <= bus.in_data;
      end
   end

endmodule

// File: tb/tb_matrix_multiply_seq.sv
// ---------------------------------------------------------------------------
// tb_matrix_multiply_seq
//   Self-checking bench for matrix_multiply_seq. Expected C elements are
//   computed from the operand matrices when a load is driven, queued, and
//   compared as the DUT hands each element over.
// ---------------------------------------------------------------------------
module tb_matrix_multiply_seq;

   localparam int N = 5;
   localparam int W = 32;

   typedef struct {
      logic [W-1:0] d;
      logic         l;
   } exp_t;

   logic clk;
   logic rst;
   logic busy;

   matrix_multiply_seq_if #(.W(W)) bus ();

   matrix_multiply_seq #(.N(N), .W(W)) dut (
      .clk  (clk),
      .rst  (rst),
      .bus  (bus),
      .busy (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int           n_checks = 0;
   int           n_fail   = 0;
   exp_t         sb[$];
   logic [W-1:0] ma [N][N];
   logic [W-1:0] mb [N][N];

   task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic timeout_fail(input string tag);
      n_checks++;
      n_fail++;
      $display("FAIL %s timeout t=%0t", tag, $time);
   endtask

   // Reference product, modulo 2^W.
   task automatic push_expected();
      for (int r = 0; r < N; r++) begin
         for (int c = 0; c < N; c++) begin
            logic [W-1:0] s;
            exp_t e;
            s = '0;
            for (int kk = 0; kk < N; kk++) s = s + ma[r][kk] * mb[kk][c];
            e.d = s;
            e.l = (r == N-1) && (c == N-1);
            sb.push_back(e);
         end
      end
   endtask

   // Drive cnt words of A/B; full loads also queue the expected product.
   task automatic load(input bit gaps, input int cnt);
      int idx  = 0;
      int cyc  = 0;
      bit bchk = 0;
      if (cnt == 2*N*N) push_expected();
      while (idx < cnt) begin
         @(negedge clk);
         if (idx >= 1 && !bchk) begin
            check("busy_rise", W'(busy), W'(1));
            bchk = 1;
         end
         cyc++;
         if (cyc > 5000) begin
            timeout_fail("load");
            break;
         end
         bus.in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
         bus.in_data  = (idx < N*N) ? ma[idx/N][idx%N] : mb[(idx-N*N)/N][(idx-N*N)%N];
         if (bus.in_valid && bus.in_ready) idx++;
      end
      @(negedge clk);
      bus.in_valid = 1'b0;
      if (!bchk) check("busy_rise", W'(busy), W'(1));
   endtask

   // Consume N*N results. stall: cycles out_ready stays low per element.
   // abort_at >= 0: stall on that element a few cycles and return early.
   task automatic collect(input int stall, input bit chk_gap, input int abort_at);
      int           got     = 0;
      int           cyc     = 0;
      int           stalled = 0;
      int           gap     = -1;
      bit           holding = 0;
      logic [W-1:0] held_d;
      logic         held_l;
      exp_t         e;
      while (got < N*N) begin
         @(negedge clk);
         cyc++;
         if (cyc > 20000) begin
            timeout_fail("collect");
            bus.out_ready = 1'b0;
            return;
         end
         if (!bus.out_valid) begin
            bus.out_ready = 1'b0;
            if (gap >= 0) gap++;
            holding = 0;
            continue;
         end
         if (chk_gap && gap >= 0) check("out_gap", W'(gap), W'(N));
         gap = -1;
         if (holding) begin
            check("stall_data", bus.out_data, held_d);
            check("stall_last", W'(bus.out_last), W'(held_l));
         end
         if (sb.size() == 0) begin
            timeout_fail("scoreboard_empty");
            bus.out_ready = 1'b0;
            return;
         end
         if (got == abort_at && stalled >= 3) begin
            e = sb[0];
            check("abort_data", bus.out_data, e.d);
            bus.out_ready = 1'b0;
            return;
         end
         if (stalled >= stall && got != abort_at) begin
            bus.out_ready = 1'b1;
            e = sb.pop_front();
            check("c_data", bus.out_data, e.d);
            check("c_last", W'(bus.out_last), W'(e.l));
            got++;
            stalled = 0;
            holding = 0;
            gap     = 0;
         end else begin
            bus.out_ready = 1'b0;
            stalled++;
            holding = 1;
            held_d  = bus.out_data;
            held_l  = bus.out_last;
         end
      end
      @(negedge clk);
      bus.out_ready = 1'b0;
      check("busy_fall", W'(busy), W'(0));
      check("valid_end", W'(bus.out_valid), W'(0));
      check("ready_end", W'(bus.in_ready), W'(1));
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      @(negedge clk);
      check("rst_in_ready", W'(bus.in_ready), W'(0));
      check("rst_busy", W'(busy), W'(0));
      check("rst_out_valid", W'(bus.out_valid), W'(0));
      check("rst_out_data", bus.out_data, '0);
      check("rst_out_last", W'(bus.out_last), W'(0));
      rst = 1'b0;
      @(negedge clk);
      check("rst_in_ready_rise", W'(bus.in_ready), W'(1));
      sb.delete();
   endtask

   task automatic fill_random();
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++) begin
            ma[r][c] = $urandom();
            mb[r][c] = $urandom();
         end
   endtask

   initial begin
      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b0;
      repeat (3) @(negedge clk);
      check("init_in_ready", W'(bus.in_ready), W'(0));
      check("init_out_valid", W'(bus.out_valid), W'(0));
      check("init_out_data", bus.out_data, '0);
      check("init_out_last", W'(bus.out_last), W'(0));
      check("init_busy", W'(busy), W'(0));
      rst = 1'b0;
      @(negedge clk);
      check("init_in_ready_rise", W'(bus.in_ready), W'(1));

      // Identity x B, with output spacing checked at full throughput.
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++) begin
            ma[r][c] = (r == c) ? 1 : 0;
            mb[r][c] = W'(10*r + c);
         end
      check("identity_last_value", mb[N-1][N-1], W'(44));
      load(0, 2*N*N);
      collect(0, 1, -1);

      // Signed: (-1) * 2 summed five times.
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++) begin
            ma[r][c] = 32'hFFFF_FFFF;
            mb[r][c] = 32'd2;
         end
      load(0, 2*N*N);
      collect(0, 1, -1);

      // Wrap-around: 2^16 * 2^16 truncates to zero.
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++) begin
            ma[r][c] = 32'h0001_0000;
            mb[r][c] = 32'h0001_0000;
         end
      load(0, 2*N*N);
      collect(0, 1, -1);

      // Input gaps and output backpressure.
      fill_random();
      load(1, 2*N*N);
      collect(7, 0, -1);

      // Reset after 30 input words, then a fresh load.
      fill_random();
      load(0, 30);
      do_reset();
      fill_random();
      load(0, 2*N*N);
      collect(0, 1, -1);

      // Reset while stalled on element 12, then a fresh load.
      fill_random();
      load(0, 2*N*N);
      collect(0, 0, 11);
      do_reset();
      fill_random();
      load(1, 2*N*N);
      collect(2, 0, -1);

      // Back-to-back: upper-triangular ones times its inverse, then new data.
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++) begin
            ma[r][c] = (c >= r) ? 32'd1 : 32'd0;
            mb[r][c] = (c == r) ? 32'd1 : ((c == r + 1) ? 32'hFFFF_FFFF : 32'd0);
         end
      load(0, 2*N*N);
      collect(0, 1, -1);
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++) begin
            ma[r][c] = W'(3*r - c + 1);
            mb[r][c] = W'(r * 7 + c * c - 4);
         end
      load(0, 2*N*N);
      collect(0, 1, -1);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
